pc_stack_ctrl: RTL and testbench

- Next-address stage for the program counter.
- Owns the 11-bit fetch address that drives the rom `counter` input.
- Resolves sequential fetch, GOTO, CALL, RETURN and skip-next decisions from the decode stage.
- Holds an 8-level return-address stack and inserts one flush bubble after every taken control transfer.

---
 rtl/pc_stack_ctrl.sv | 111 +++++++++++
 tb/tb_pc_stack_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: next fetch address with an 8-deep return stack and a one-cycle flush bubble.
// Define STACK_TRAP_EN to halt on stack overflow/underflow instead of overwriting/ignoring.
module pc_stack_ctrl #(
    parameter int AW        = 11,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] counter,
    output logic          fetch_valid,
    output logic [3:0]    stack_depth,
    output logic          overflow,
    output logic          underflow,
    output logic          halted
);
    localparam int SPW = $clog2(DEPTH);
    localparam logic [3:0] FULL = 4'(DEPTH);
    localparam logic [2:0] OP_GOTO = 3'd1, OP_CALL = 3'd2, OP_RET = 3'd3, OP_SKIP = 3'd4;
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [AW-1:0] stack_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d, sp_dec;
    logic [3:0] depth_q, depth_d;
    logic ovf_q, ovf_d, unf_q, unf_d, push, full, empty, trap;
    assign pc_inc = pc_q + AW'(1);
    assign sp_dec = sp_q - SPW'(1);
    assign full   = depth_q == FULL;
    assign empty  = depth_q == 4'd0;
`ifdef STACK_TRAP_EN
    assign trap   = 1'b1;
    assign halted = state_q == HALT;
`else
    assign trap   = 1'b0;
    assign halted = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (advance && state_q == FLUSH) begin
            pc_d    = pc_inc;
            state_d = RUN;
        end else if (advance && state_q == RUN) begin
            pc_d = pc_inc;
            if (op == OP_SKIP) begin
                pc_d = pc_q + AW'(2);
            end else if (op == OP_GOTO) begin
                pc_d    = target;
                state_d = FLUSH;
            end else if (op == OP_CALL) begin
                ovf_d = ovf_q | full;
                if (full && trap) begin
                    pc_d    = pc_q;
                    state_d = HALT;
                end else begin
                    // a full stack acts as a circular buffer: the oldest entry is overwritten
                    push    = 1'b1;
                    sp_d    = sp_q + SPW'(1);
                    depth_d = full ? depth_q : depth_q + 4'd1;
                    pc_d    = target;
                    state_d = FLUSH;
                end
            end else if (op == OP_RET) begin
                unf_d = unf_q | empty;
                if (!empty) begin
                    sp_d    = sp_dec;
                    depth_d = depth_q - 4'd1;
                    pc_d    = stack_q[sp_dec];
                    state_d = FLUSH;
                end else if (trap) begin
                    pc_d    = pc_q;
                    state_d = HALT;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= AW'(RESET_VEC);
            sp_q    <= '0;
            depth_q <= 4'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) stack_q[sp_q] <= pc_inc;
    end
    assign counter     = pc_q;
    assign fetch_valid = state_q == RUN;
    assign stack_depth = depth_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb_pc_stack_ctrl: directed scoreboard bench for pc_stack_ctrl (default build).
module tb_pc_stack_ctrl;
    logic clk = 1'b0, reset, advance;
    logic [2:0] op;
    logic [10:0] target, counter;
    logic fetch_valid, overflow, underflow, halted;
    logic [3:0] stack_depth;
    typedef struct {
        logic [10:0] cnt;
        logic fv;
        logic [3:0] dep;
        logic ovf, unf;
    } exp_t;
    exp_t sb[$];
    logic [10:0] rs[$];
    int total = 0, bad = 0;
    logic e_ovf = 1'b0, e_unf = 1'b0;

    pc_stack_ctrl dut (
        .clk(clk), .reset(reset), .advance(advance), .op(op), .target(target),
        .counter(counter), .fetch_valid(fetch_valid), .stack_depth(stack_depth),
        .overflow(overflow), .underflow(underflow), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string f, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s.%s got=%0h want=%0h", tag, f, got, want);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic a, input logic [2:0] o,
                        input logic [10:0] t, input logic [10:0] c, input logic fv, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        reset = r; advance = a; op = o; target = t;
        e = '{c, fv, d, e_ovf, e_unf};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, "counter", 32'(counter), 32'(e.cnt));
        chk(tag, "fetch_valid", 32'(fetch_valid), 32'(e.fv));
        chk(tag, "depth", 32'(stack_depth), 32'(e.dep));
        chk(tag, "overflow", 32'(overflow), 32'(e.ovf));
        chk(tag, "underflow", 32'(underflow), 32'(e.unf));
        chk(tag, "halted", 32'(halted), 32'(0));
    endtask

    initial begin
        logic [10:0] c, t, r;
        reset = 1'b1; advance = 1'b0; op = 3'd0; target = 11'd0;
        step("reset", 1, 0, 0, 0, 11'h000, 1, 0);
        for (int i = 1; i <= 5; i++) step("inc", 0, 1, 0, 0, 11'(i), 1, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 1, 11'h555, 11'h005, 1, 0);
        step("goto_pre", 0, 1, 1, 11'h00F, 11'h00F, 0, 0);
        step("flush_ign", 0, 1, 2, 11'h700, 11'h010, 1, 0);
        step("goto", 0, 1, 1, 11'h100, 11'h100, 0, 0);
        step("goto_fl", 0, 1, 0, 0, 11'h101, 1, 0);
        step("goto_pre2", 0, 1, 1, 11'h01F, 11'h01F, 0, 0);
        step("goto_fl2", 0, 1, 0, 0, 11'h020, 1, 0);
        step("call", 0, 1, 2, 11'h300, 11'h300, 0, 1);
        step("call_fl", 0, 1, 0, 0, 11'h301, 1, 1);
        step("call_inc", 0, 1, 0, 0, 11'h302, 1, 1);
        step("ret", 0, 1, 3, 0, 11'h021, 0, 0);
        step("ret_fl", 0, 1, 0, 0, 11'h022, 1, 0);
        c = 11'h022;
        for (int i = 0; i < 9; i++) begin
            t = 11'h400 + 11'(i * 16);
            rs.push_back(c + 11'd1);
            if (rs.size() > 8) begin
                void'(rs.pop_front());
                e_ovf = 1'b1;
            end
            step("ncall", 0, 1, 2, t, t, 0, 4'(rs.size()));
            c = t + 11'd1;
            step("ncall_fl", 0, 1, 0, 0, c, 1, 4'(rs.size()));
        end
        for (int i = 0; i < 8; i++) begin
            r = rs.pop_back();
            step("nret", 0, 1, 3, 0, r, 0, 4'(rs.size()));
            step("nret_fl", 0, 1, 0, 0, r + 11'd1, 1, 4'(rs.size()));
        end
        step("g040", 0, 1, 1, 11'h03F, 11'h03F, 0, 0);
        step("g040_fl", 0, 1, 0, 0, 11'h040, 1, 0);
        e_unf = 1'b1;
        step("uret", 0, 1, 3, 0, 11'h041, 1, 0);
        step("uret_next", 0, 1, 0, 0, 11'h042, 1, 0);
        step("skip", 0, 1, 4, 0, 11'h044, 1, 0);
        step("g7fe", 0, 1, 1, 11'h7FD, 11'h7FD, 0, 0);
        step("g7fe_fl", 0, 1, 0, 0, 11'h7FE, 1, 0);
        step("skip_wrap", 0, 1, 4, 0, 11'h000, 1, 0);
        step("g7ff", 0, 1, 1, 11'h7FE, 11'h7FE, 0, 0);
        step("g7ff_fl", 0, 1, 0, 0, 11'h7FF, 1, 0);
        step("call_wrap", 0, 1, 2, 11'h005, 11'h005, 0, 1);
        step("call_wrap_fl", 0, 1, 0, 0, 11'h006, 1, 1);
        step("ret_wrap", 0, 1, 3, 0, 11'h000, 0, 0);
        e_ovf = 1'b0; e_unf = 1'b0;
        step("reset_flush", 1, 1, 0, 0, 11'h000, 1, 0);
        step("post_reset", 0, 1, 0, 0, 11'h001, 1, 0);
        step("post_call", 0, 1, 2, 11'h200, 11'h200, 0, 1);
        step("post_call_fl", 0, 1, 0, 0, 11'h201, 1, 1);
        step("post_ret", 0, 1, 3, 0, 11'h002, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
